// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: FSM state codes, handshake levels
// and the default operand width.
package div_unit_pkg;

   localparam int DIV_DATA_W = 32;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one and subtract the
// divisor from the widened remainder when it fits.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] quo_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] rem_nxt,
   output logic [W-1:0] quo_nxt
);

   logic [W:0]   shifted;
   logic [W-1:0] diff;

   assign shifted = {rem_i, quo_i[W-1]};
   // rem_i < divisor_i, so a successful subtract always fits back into W bits.
   assign diff    = shifted[W-1:0] - divisor_i;

   always_comb begin
      rem_nxt = shifted[W-1:0];
      quo_nxt = {quo_i[W-2:0], 1'b0};
      if (shifted >= {1'b0, divisor_i}) begin
         rem_nxt = diff;
         quo_nxt = {quo_i[W-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle on
// magnitudes, sign fixup on entry to END, result held while start_i stays high.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   div_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]   quo_q, quo_d;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic                ready_d;
   logic [2*DATA_W-1:0] result_d;
   logic [DATA_W-1:0]   step_rem, step_quo;
   logic                op1_neg, op2_neg;

   div_step #(.W(DATA_W)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_nxt   (step_rem),
      .quo_nxt   (step_quo)
   );

   assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
   assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= DIV_FREE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ready_o   <= DIV_RESULT_NOT_READY;
         result_o  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         ready_o   <= ready_d;
         result_o  <= result_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      case (state_q)
         DIV_FREE: begin
            if (start_i == DIV_START && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = DIV_BY_ZERO;
               end else begin
                  state_d   = DIV_ON;
                  cnt_d     = '0;
                  rem_d     = '0;
                  quo_d     = op1_neg ? -opdata1_i : opdata1_i;
                  dvs_d     = op2_neg ? -opdata2_i : opdata2_i;
                  neg_quo_d = op1_neg ^ op2_neg;
                  neg_rem_d = op1_neg;
               end
            end
         end
         DIV_BY_ZERO: begin
            state_d = DIV_END;
            rem_d   = '0;
            quo_d   = '0;
         end
         DIV_ON: begin
            if (annul_i) begin
               state_d = DIV_FREE;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + CNT_W'(1);
               // Last step: store the signed result so END only has to present it.
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = DIV_END;
                  quo_d   = neg_quo_q ? -step_quo : step_quo;
                  rem_d   = neg_rem_q ? -step_rem : step_rem;
               end
            end
         end
         DIV_END: begin
            // Leave only after the result has been shown for at least one cycle.
            if (start_i == DIV_STOP && ready_o == DIV_RESULT_READY)
               state_d = DIV_FREE;
         end
         default: state_d = DIV_FREE;
      endcase
   end

   always_comb begin
      ready_d  = (state_q == DIV_END) && (state_d == DIV_END);
      result_d = ready_d ? {rem_q, quo_q} : '0;
   end

endmodule
